multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter WORD_W, default 16: operand/sum word width per beat.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1: upstream beat valid.
REQ-005 SHALL have port in_ready  output  1: block accepts beat this cycle.
REQ-006 SHALL have port in_a  input  WORD_W: operand A word, least-significant word first.
REQ-007 SHALL have port in_b  input  WORD_W: operand B word.
REQ-008 SHALL have port in_first  input  1: beat is first word of a multi-word operand.
REQ-009 SHALL have port in_last  input  1: beat is last word.
REQ-010 SHALL have port in_cin  input  1: carry-in, sampled only on a first beat.
REQ-011 SHALL have port out_valid  output  1: result beat valid.
REQ-012 SHALL have port out_ready  input  1: downstream accepts result.
REQ-013 SHALL have port out_sum  output  WORD_W: sum word.
REQ-014 SHALL have port out_last  output  1: result is last word of operand.
REQ-015 SHALL have port out_cout  output  1: final carry-out, meaningful only when out_last=1, else 0.
REQ-016 SHALL have port proto_err  output  1: one-cycle pulse on protocol violation.

Function
REQ-017 SHALL accept a beat when in_valid and in_ready are both 1; in_ready = !out_valid | out_ready (combinational).
REQ-018 SHALL compute per accepted beat {c, out_sum} = in_a + in_b + cy, width WORD_W+1, cy = in_first ? in_cin : carry_q.
REQ-019 SHALL register the result so out_valid rises the cycle after acceptance (latency 1), sustaining one beat per cycle under continuous out_ready=1.
REQ-020 SHALL hold out_sum/out_last/out_cout stable while out_valid=1 and out_ready=0.
REQ-021 SHALL update carry_q <= c on every accepted beat; carry_q SHALL NOT change on unaccepted cycles.
REQ-022 SHALL implement FSM IDLE/IN_PKT: IDLE->IN_PKT on accepted beat with in_last=0; IN_PKT->IDLE on accepted beat with in_last=1; otherwise hold.
REQ-023 SHALL treat a beat in IDLE with in_first=0 as a first beat (cy = in_cin) and pulse proto_err the following cycle.
REQ-024 SHALL treat a beat in IN_PKT with in_first=1 as a restart (cy = in_cin), discard prior packet without flagging out_last, and pulse proto_err.
REQ-025 SHALL handle single-beat operands (in_first=in_last=1) in IDLE, returning to IDLE with out_last=1.
REQ-026 SHALL drive out_cout = c of the last beat, out_cout=0 on non-last beats.
REQ-027 SHALL ignore in_a/in_b/in_first/in_last/in_cin when not accepted.

Reset
REQ-028 SHALL on rst_n=0 asynchronously force FSM=IDLE, carry_q=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, proto_err=0.
REQ-029 SHALL drop any in-flight packet on reset; first beat after rst_n release is processed as a first beat.
REQ-030 SHALL drive in_ready=1 during and after reset while out_valid=0.

Configuration
REQ-031 SHALL, with ADD_SUB_EN defined, add port in_sub input 1, sampled on first beat and held for the packet; when 1: in_b replaced by ~in_b every beat, first-beat cy forced to 1 (in_cin ignored), out_cout = no-borrow flag.
REQ-032 SHALL, without ADD_SUB_EN, have no in_sub port and perform addition only.

Verification
REQ-033 SHALL pass: single beat a=16'hFFFF, b=16'h0001, cin=0, first=last=1 -> next cycle out_sum=16'h0000, out_last=1, out_cout=1.
REQ-034 SHALL pass: 2-beat 32-bit add 0x0000FFFF+0x00000001 (word0 FFFF+0001, word1 0000+0000) -> out_sum 0000 then 0001, out_cout=0 on last.
REQ-035 SHALL pass: 4-beat stream with out_ready=0 for 3 cycles after beat 1 -> in_ready=0 while stalled, outputs held, no beat lost, carry chain correct.
REQ-036 SHALL pass: beat with in_first=0 in IDLE -> proto_err=1 for one cycle, sum uses in_cin; beat with in_first=1 mid-packet -> proto_err pulse, carry restarted.
REQ-037 SHALL pass: rst_n=0 mid-packet after beat 1 of 3 -> out_valid=0, carry_q=0 immediately; next beat with in_first=1 produces correct sum.
REQ-038 SHALL pass (ADD_SUB_EN): in_sub=1, single beat a=16'h0005, b=16'h0007 -> out_sum=16'hFFFE, out_cout=0; a=7, b=5 -> out_sum=16'h0002, out_cout=1.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-word sequential adder: one WORD_W slice per beat, LS word first, carry chained across beats.
// Optional subtract mode is enabled by defining ADD_SUB_EN (adds the in_sub port).
module multiword_add_seq #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_cin,
`ifdef ADD_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              proto_err
);

  // state   | meaning
  // S_IDLE  | between packets, next beat starts a new operand
  // S_IN_PKT| mid-packet, carry_q chains into the next beat
  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  state_t            r_state;
  logic              r_carry;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_sum;
  logic              r_out_last;
  logic              r_out_cout;
  logic              r_proto_err;
`ifdef ADD_SUB_EN
  logic              r_sub;
`endif

  logic              w_accept;
  logic              w_restart;
  logic              w_err;
  logic              w_sub;
  logic [WORD_W-1:0] w_b;
  logic              w_cy;
  logic [WORD_W:0]   w_full;

  assign in_ready  = ~r_out_valid | out_ready;
  assign w_accept  = in_valid & in_ready;

  // A beat in IDLE always starts a packet; in_first mid-packet restarts one.
  assign w_restart = (r_state == S_IDLE) | in_first;
  assign w_err     = (r_state == S_IDLE) ? ~in_first : in_first;

`ifdef ADD_SUB_EN
  assign w_sub = w_restart ? in_sub : r_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtraction is a + ~b + 1; the forced first-beat carry supplies the +1.
  assign w_b    = w_sub ? ~in_b : in_b;
  assign w_cy   = w_restart ? (w_sub | in_cin) : r_carry;
  assign w_full = {1'b0, in_a} + {1'b0, w_b} + {{WORD_W{1'b0}}, w_cy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_proto_err <= 1'b0;
`ifdef ADD_SUB_EN
      r_sub       <= 1'b0;
`endif
    end else begin
      r_proto_err <= w_accept & w_err;
      if (w_accept) begin
        r_carry     <= w_full[WORD_W];
        r_out_valid <= 1'b1;
        r_out_sum   <= w_full[WORD_W-1:0];
        r_out_last  <= in_last;
        r_out_cout  <= in_last & w_full[WORD_W];
        r_state     <= in_last ? S_IDLE : S_IN_PKT;
`ifdef ADD_SUB_EN
        r_sub       <= w_sub;
`endif
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: vector table for streaming beats plus stall/reset sequences.
module tb_multiword_add_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_first, in_last, in_cin;
  logic         tb_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last, out_cout, proto_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multiword_add_seq #(.WORD_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .in_cin   (in_cin),
`ifdef ADD_SUB_EN
    .in_sub   (tb_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_cout (out_cout),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         first;
    logic         last;
    logic         cin;
    logic [W-1:0] e_sum;
    logic         e_last;
    logic         e_cout;
    logic         e_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic first, input logic last, input logic cin);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    in_cin   = cin;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] s, input logic l,
                         input logic c, input logic e);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".cout"},  32'(out_cout),  32'(c));
    chk({tag, ".err"},   32'(proto_err), 32'(e));
  endtask

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'h1234, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h2346, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{16'h0010, 16'h0020, 1'b0, 1'b1, 1'b1, 16'h0031, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0006, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tb_sub = 1'b0;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_cin = 1'b0;
    #12;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_sum",   32'(out_sum),   32'd0);
    chk("rst.out_last",  32'(out_last),  32'd0);
    chk("rst.out_cout",  32'(out_cout),  32'd0);
    chk("rst.proto_err", 32'(proto_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back streaming with out_ready held high.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].first, vecs[i].last, vecs[i].cin);
      chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_sum, vecs[i].e_last, vecs[i].e_cout, vecs[i].e_err);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.out_valid", 32'(out_valid), 32'd0);
    chk("drain.proto_err", 32'(proto_err), 32'd0);

    // Four-beat packet with a 3-cycle downstream stall after beat 1.
    @(negedge clk); drive(16'hFFF0, 16'h0011, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1; chk_out("stall.b0", 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1; chk_out("stall.b1", 16'h1235, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall.c%0d.in_ready", k), 32'(in_ready), 32'd0);
      chk_out($sformatf("stall.c%0d.hold", k), 16'h1235, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; chk_out("stall.b2", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1; chk_out("stall.b3", 16'h0001, 1'b1, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0;

    // Reset after beat 1 of a 3-beat packet.
    @(negedge clk); drive(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1; chk_out("rstpkt.b0", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("rstpkt.out_valid", 32'(out_valid), 32'd0);
    chk("rstpkt.in_ready",  32'(in_ready),  32'd1);
    chk("rstpkt.carry_q",   32'(dut.r_carry), 32'd0);
    chk("rstpkt.out_sum",   32'(out_sum),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive(16'h0001, 16'h0001, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1; chk_out("rstpkt.new", 16'h0002, 1'b1, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;

`ifdef ADD_SUB_EN
    @(negedge clk); drive(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0); tb_sub = 1'b1;
    @(posedge clk); #1; chk_out("sub.5m7", 16'hFFFE, 1'b1, 1'b0, 1'b0);
    @(negedge clk); drive(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1; chk_out("sub.7m5", 16'h0002, 1'b1, 1'b1, 1'b0);
    @(negedge clk); in_valid = 1'b0; tb_sub = 1'b0;
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
